// File: rtl/axis_sched_pkg.sv
// Shared types and default widths for the AXI-Stream destination scheduler.
// Used by axis_dest_scheduler (optional packet counters: AXIS_SCHED_PKT_CNT_EN).
package axis_sched_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_DEST_WIDTH = 32;
    localparam int DEFAULT_KEEP_WIDTH = DEFAULT_DATA_WIDTH / 8;
    localparam int CNT_WIDTH          = 16;

    // Plain vector states keep the encoding visible to legacy tooling.
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t ST_IDLE = 2'd0;
    localparam sched_state_t ST_ADDR = 2'd1;
    localparam sched_state_t ST_DATA = 2'd2;

    function automatic int next_ptr(input int idx, input int num_ports);
        return (idx + 1) % num_ports;
    endfunction

endpackage

// File: rtl/axis_dest_scheduler_if.sv
// Packet, destination and address-token streams of axis_dest_scheduler.
// Modport master is the scheduler view, slave the sources/sinks view.
interface axis_dest_scheduler_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 32
) ();
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [NUM_PORTS*DATA_WIDTH-1:0] s_packet_axis_tdata;
    logic [NUM_PORTS*KEEP_WIDTH-1:0] s_packet_axis_tkeep;
    logic [NUM_PORTS-1:0]            s_packet_axis_tvalid;
    logic [NUM_PORTS-1:0]            s_packet_axis_tlast;
    logic [NUM_PORTS*DEST_WIDTH-1:0] s_packet_axis_tdest;
    logic [NUM_PORTS-1:0]            s_packet_axis_tready;

    logic [DATA_WIDTH-1:0]           m_packet_axis_tdata;
    logic [KEEP_WIDTH-1:0]           m_packet_axis_tkeep;
    logic                            m_packet_axis_tvalid;
    logic                            m_packet_axis_tlast;
    logic [DEST_WIDTH-1:0]           m_packet_axis_tdest;
    logic                            m_packet_axis_tready;

    logic [DEST_WIDTH-1:0]           m_addr_axis_tdata;
    logic                            m_addr_axis_tvalid;
    logic                            m_addr_axis_tlast;
    logic                            m_addr_axis_tready;

    modport master (
        input  s_packet_axis_tdata, s_packet_axis_tkeep, s_packet_axis_tvalid,
               s_packet_axis_tlast, s_packet_axis_tdest,
               m_packet_axis_tready, m_addr_axis_tready,
        output s_packet_axis_tready,
               m_packet_axis_tdata, m_packet_axis_tkeep, m_packet_axis_tvalid,
               m_packet_axis_tlast, m_packet_axis_tdest,
               m_addr_axis_tdata, m_addr_axis_tvalid, m_addr_axis_tlast
    );

    modport slave (
        output s_packet_axis_tdata, s_packet_axis_tkeep, s_packet_axis_tvalid,
               s_packet_axis_tlast, s_packet_axis_tdest,
               m_packet_axis_tready, m_addr_axis_tready,
        input  s_packet_axis_tready,
               m_packet_axis_tdata, m_packet_axis_tkeep, m_packet_axis_tvalid,
               m_packet_axis_tlast, m_packet_axis_tdest,
               m_addr_axis_tdata, m_addr_axis_tvalid, m_addr_axis_tlast
    );
endinterface

// File: rtl/axis_dest_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above pointer, with wrap.
module rr_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] pointer,
    output logic [$clog2(NUM_PORTS)-1:0] gnt_idx,
    output logic                         gnt_valid
);
    localparam int IDX_WIDTH = $clog2(NUM_PORTS);

    int cand;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = int'(pointer) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_WIDTH'(cand);
            end
        end
    end
endmodule

// File: rtl/axis_dest_scheduler.sv
// Packet-granular round-robin scheduler: one destination token, then the packet beats.
// Optional per-port tlast counters via `define AXIS_SCHED_PKT_CNT_EN.
module axis_dest_scheduler
    import axis_sched_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEST_WIDTH = DEFAULT_DEST_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    axis_dest_scheduler_if.master        bus,
    output logic [$clog2(NUM_PORTS)-1:0] grant,
    output logic                         busy
`ifdef AXIS_SCHED_PKT_CNT_EN
    ,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_count
`endif
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = $clog2(NUM_PORTS);

    sched_state_t          state;
    logic [IDX_WIDTH-1:0]  pointer;
    logic [IDX_WIDTH-1:0]  arb_idx;
    logic                  arb_valid;
    logic [DEST_WIDTH-1:0] dest_reg;
    logic [DEST_WIDTH-1:0] req_dest;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  in_data;
    logic                  pkt_last_hs;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req       (bus.s_packet_axis_tvalid),
        .pointer   (pointer),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign req_dest = bus.s_packet_axis_tdest[int'(arb_idx)*DEST_WIDTH +: DEST_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            pointer  <= '0;
            grant    <= '0;
            dest_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant    <= arb_idx;
                        dest_reg <= req_dest;
                        pointer  <= IDX_WIDTH'(next_ptr(int'(arb_idx), NUM_PORTS));
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: if (bus.m_addr_axis_tready) state <= ST_DATA;
                ST_DATA: if (pkt_last_hs) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Packet outputs depend only on state and the granted source, never on the token ready.
    always_comb begin
        in_data   = (state == ST_DATA);
        sel_data  = bus.s_packet_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = bus.s_packet_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
        sel_valid = bus.s_packet_axis_tvalid[grant];
        sel_last  = bus.s_packet_axis_tlast[grant];

        bus.m_packet_axis_tvalid = in_data & sel_valid;
        bus.m_packet_axis_tlast  = in_data & sel_last;
        bus.m_packet_axis_tdata  = in_data ? sel_data : '0;
        bus.m_packet_axis_tkeep  = in_data ? sel_keep : '0;
        bus.m_packet_axis_tdest  = dest_reg;

        bus.s_packet_axis_tready = '0;
        if (in_data) begin
            bus.s_packet_axis_tready[grant] = bus.m_packet_axis_tready;
        end

        bus.m_addr_axis_tvalid = (state == ST_ADDR);
        bus.m_addr_axis_tlast  = (state == ST_ADDR);
        bus.m_addr_axis_tdata  = dest_reg;

        busy        = (state != ST_IDLE);
        pkt_last_hs = in_data & sel_valid & sel_last & bus.m_packet_axis_tready;
    end

`ifdef AXIS_SCHED_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt [NUM_PORTS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt[i] <= '0;
            end
        end else if (pkt_last_hs && (cnt[grant] != '1)) begin
            cnt[grant] <= cnt[grant] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end
`endif
endmodule

// File: tb/tb_axis_dest_scheduler.sv
// Randomized bench for axis_dest_scheduler against a packet-level round-robin model.
// Also checks pkt_count when built with AXIS_SCHED_PKT_CNT_EN.
module tb_axis_dest_scheduler;
    import axis_sched_pkg::*;

    localparam int NP   = 4;
    localparam int DW   = 64;
    localparam int DTW  = 32;
    localparam int KW   = DW / 8;
    localparam int IW   = 2;
    localparam int MAXP = 8;
    localparam int MAXB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] grant;
    logic          busy;
`ifdef AXIS_SCHED_PKT_CNT_EN
    logic [NP*16-1:0] pkt_count;
`endif

    always #5 clk = ~clk;

    axis_dest_scheduler_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEST_WIDTH(DTW)) bus ();

    axis_dest_scheduler #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEST_WIDTH(DTW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
`ifdef AXIS_SCHED_PKT_CNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Packet store: what each source will send, in order.
    int            n_pkts   [NP];
    int            pkt_len  [NP][MAXP];
    logic [DTW-1:0] pkt_dest [NP][MAXP];
    logic [DW-1:0] pkt_data [NP][MAXP][MAXB];
    logic [KW-1:0] pkt_keep [NP][MAXP][MAXB];
    int            src_pkt  [NP];
    int            src_beat [NP];

    // Model and observation state.
    int mdl_ptr;
    int exp_pkt   [NP];
    int delivered [NP];
    int total_beats_exp;
    int beats_seen;
    int last_beat_cycle;
    int addr_valid_cycles;
    int grant_log  [$];
    int token_cycle[$];

    task automatic do_reset();
        rst = 1'b0;
        bus.s_packet_axis_tvalid = '0;
        bus.s_packet_axis_tlast  = '0;
        bus.s_packet_axis_tdata  = '0;
        bus.s_packet_axis_tkeep  = '0;
        bus.s_packet_axis_tdest  = '0;
        bus.m_packet_axis_tready = 1'b0;
        bus.m_addr_axis_tready   = 1'b0;
        for (int i = 0; i < NP; i++) begin
            n_pkts[i] = 0; src_pkt[i] = 0; src_beat[i] = 0;
            exp_pkt[i] = 0; delivered[i] = 0;
        end
        mdl_ptr = 0; total_beats_exp = 0; beats_seen = 0;
        last_beat_cycle = -1; addr_valid_cycles = 0;
        grant_log.delete(); token_cycle.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic add_packet(input int port, input int len, input logic [DTW-1:0] dest);
        int p;
        p = n_pkts[port];
        pkt_len[port][p]  = len;
        pkt_dest[port][p] = dest;
        for (int b = 0; b < len; b++) begin
            pkt_data[port][p][b] = {$urandom, $urandom};
            pkt_keep[port][p][b] = KW'($urandom);
        end
        n_pkts[port]++;
        total_beats_exp += len;
    endtask

    task automatic drive_sources(input int gap_pct);
        int p, b;
        for (int i = 0; i < NP; i++) begin
            if (src_pkt[i] < n_pkts[i]) begin
                p = src_pkt[i];
                b = src_beat[i];
                bus.s_packet_axis_tvalid[i] = (b == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
                bus.s_packet_axis_tlast[i]  = (b == pkt_len[i][p] - 1);
                bus.s_packet_axis_tdata[i*DW +: DW]   = pkt_data[i][p][b];
                bus.s_packet_axis_tkeep[i*KW +: KW]   = pkt_keep[i][p][b];
                bus.s_packet_axis_tdest[i*DTW +: DTW] = pkt_dest[i][p];
            end else begin
                bus.s_packet_axis_tvalid[i] = 1'b0;
                bus.s_packet_axis_tlast[i]  = 1'b0;
            end
        end
    endtask

    // Runs all queued packets through the DUT and checks tokens and beats against the model.
    task automatic run_traffic(input int addr_pct, input int pkt_pct, input int gap_pct,
                               input int addr_stall, input int budget);
        int cyc, port, cur_port, cur_pkt, cur_beat, stall, idx;
        bit done, token_pending, in_pkt, exp_last;
        logic [NP-1:0] s_hs, exp_hs;
        logic [DW+KW+DTW:0] act_b, exp_b;
        cyc = 0; done = 0; token_pending = 0; in_pkt = 0; stall = addr_stall;
        cur_port = 0; cur_pkt = 0; cur_beat = 0;
        @(posedge clk); #1;
        drive_sources(gap_pct);
        bus.m_addr_axis_tready   = (stall > 0) ? 1'b0 : ($urandom_range(99) < addr_pct);
        bus.m_packet_axis_tready = ($urandom_range(99) < pkt_pct);
        while (!done && cyc < budget) begin
            @(negedge clk);
            s_hs = bus.s_packet_axis_tvalid & bus.s_packet_axis_tready;
            if (bus.m_addr_axis_tvalid) begin
                addr_valid_cycles++;
                if (!token_pending) begin
                    port = -1;
                    for (int k = 0; k < NP; k++) begin
                        idx = (mdl_ptr + k) % NP;
                        if (port < 0 && exp_pkt[idx] < n_pkts[idx]) port = idx;
                    end
                    tests_run++;
                    if (port < 0) begin
                        tests_failed++;
                        $display("[TB] FAIL spurious_token: got token %h, required none", bus.m_addr_axis_tdata);
                        port = 0;
                    end
                    cur_port = port; cur_pkt = exp_pkt[port];
                    exp_pkt[port]++;
                    mdl_ptr = (port + 1) % NP;
                    token_pending = 1;
                    token_cycle.push_back(cyc);
                    grant_log.push_back(int'(grant));
                    tests_run++;
                    if (int'(grant) !== cur_port) begin
                        tests_failed++;
                        $display("[TB] FAIL token_grant: got %0d, required %0d", grant, cur_port);
                    end
                end
                tests_run++;
                if ({bus.m_addr_axis_tdata, bus.m_addr_axis_tlast} !== {pkt_dest[cur_port][cur_pkt], 1'b1}) begin
                    tests_failed++;
                    $display("[TB] FAIL token_data: got %h/%b, required %h/1", bus.m_addr_axis_tdata,
                             bus.m_addr_axis_tlast, pkt_dest[cur_port][cur_pkt]);
                end
                tests_run++;
                if ({bus.s_packet_axis_tready, bus.m_packet_axis_tvalid} !== '0) begin
                    tests_failed++;
                    $display("[TB] FAIL token_quiet: got tready %b pvalid %b, required 0/0",
                             bus.s_packet_axis_tready, bus.m_packet_axis_tvalid);
                end
                if (bus.m_addr_axis_tready) begin
                    token_pending = 0; in_pkt = 1; cur_beat = 0;
                end
            end
            if (bus.m_packet_axis_tvalid && bus.m_packet_axis_tready) begin
                tests_run++;
                if (!in_pkt) begin
                    tests_failed++;
                    $display("[TB] FAIL unexpected_beat: got beat %h, required none", bus.m_packet_axis_tdata);
                end else begin
                    exp_last = (cur_beat == pkt_len[cur_port][cur_pkt] - 1);
                    act_b = {bus.m_packet_axis_tdata, bus.m_packet_axis_tkeep,
                             bus.m_packet_axis_tlast, bus.m_packet_axis_tdest};
                    exp_b = {pkt_data[cur_port][cur_pkt][cur_beat], pkt_keep[cur_port][cur_pkt][cur_beat],
                             exp_last, pkt_dest[cur_port][cur_pkt]};
                    if (act_b !== exp_b) begin
                        tests_failed++;
                        $display("[TB] FAIL beat_content: got %h, required %h", act_b, exp_b);
                    end
                    exp_hs = '0;
                    exp_hs[cur_port] = 1'b1;
                    tests_run++;
                    if (s_hs !== exp_hs) begin
                        tests_failed++;
                        $display("[TB] FAIL src_consume: got %b, required %b", s_hs, exp_hs);
                    end
                    beats_seen++;
                    cur_beat++;
                    if (exp_last) begin
                        in_pkt = 0;
                        delivered[cur_port]++;
                        last_beat_cycle = cyc;
                    end
                end
            end
            if (beats_seen == total_beats_exp && !in_pkt && !token_pending) done = 1;
            @(posedge clk); #1;
            for (int i = 0; i < NP; i++) begin
                if (s_hs[i]) begin
                    src_beat[i]++;
                    if (src_beat[i] == pkt_len[i][src_pkt[i]]) begin
                        src_beat[i] = 0;
                        src_pkt[i]++;
                    end
                end
            end
            drive_sources(gap_pct);
            if (stall > 0) stall--;
            bus.m_addr_axis_tready   = (stall > 0) ? 1'b0 : ($urandom_range(99) < addr_pct);
            bus.m_packet_axis_tready = ($urandom_range(99) < pkt_pct);
            cyc++;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("[TB] FAIL traffic_timeout: got %0d of %0d beats, required all", beats_seen, total_beats_exp);
        end
        bus.s_packet_axis_tvalid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.s_packet_axis_tvalid = '1;
        bus.m_addr_axis_tready   = 1'b1;
        bus.m_packet_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, bus.m_addr_axis_tvalid, bus.m_addr_axis_tlast, bus.m_packet_axis_tvalid,
             bus.s_packet_axis_tready} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got busy %b av %b al %b pv %b tready %b, required all 0",
                     busy, bus.m_addr_axis_tvalid, bus.m_addr_axis_tlast, bus.m_packet_axis_tvalid,
                     bus.s_packet_axis_tready);
        end
        tests_run++;
        if ({grant, bus.m_addr_axis_tdata} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs: got grant %0d dest %h, required 0/0", grant, bus.m_addr_axis_tdata);
        end
        bus.s_packet_axis_tvalid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_req: got busy %b, required 0", busy);
        end
    endtask

    task automatic test_single_packet();
        do_reset();
        add_packet(0, 3, 32'h0000_0005);
        run_traffic(100, 100, 0, 0, 50);
        tests_run++;
        if (token_cycle.size() != 1 || token_cycle[0] != 1 || last_beat_cycle != 4) begin
            tests_failed++;
            $display("[TB] FAIL single_latency: got %0d tokens, last beat cycle %0d, required 1 token at 1, last beat 4",
                     token_cycle.size(), last_beat_cycle);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NP; p++) add_packet(p, 1, DTW'(32'h1000 + p * 16 + k));
        end
        run_traffic(100, 100, 0, 0, 200);
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (k >= grant_log.size() || grant_log[k] != exp_order[k]) begin
                tests_failed++;
                $display("[TB] FAIL rr_order[%0d]: got %0d, required %0d", k,
                         (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
            end
        end
        tests_run++;
        if (token_cycle.size() < 2 || token_cycle[1] - token_cycle[0] != 3) begin
            tests_failed++;
            $display("[TB] FAIL rr_spacing: got %0d, required 3",
                     (token_cycle.size() < 2) ? -1 : token_cycle[1] - token_cycle[0]);
        end
    endtask

    task automatic test_addr_backpressure();
        do_reset();
        add_packet(2, 4, $urandom);
        run_traffic(100, 100, 0, 11, 100);
        tests_run++;
        if (addr_valid_cycles != 11) begin
            tests_failed++;
            $display("[TB] FAIL addr_hold: got %0d token cycles, required 11", addr_valid_cycles);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        add_packet($urandom_range(NP - 1), 8, $urandom);
        run_traffic(100, 50, 50, 0, 400);
        tests_run++;
        if (beats_seen != 8) begin
            tests_failed++;
            $display("[TB] FAIL gap_beats: got %0d, required 8", beats_seen);
        end
    endtask

    task automatic test_random_mix();
        do_reset();
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < int'($urandom_range(3)); k++) add_packet(p, $urandom_range(1, MAXB), $urandom);
        end
        add_packet($urandom_range(NP - 1), $urandom_range(1, MAXB), $urandom);
        run_traffic(60, 50, 30, 0, 4000);
`ifdef AXIS_SCHED_PKT_CNT_EN
        for (int p = 0; p < NP; p++) begin
            tests_run++;
            if (int'(pkt_count[p*16 +: 16]) != delivered[p]) begin
                tests_failed++;
                $display("[TB] FAIL pkt_count[%0d]: got %0d, required %0d", p, pkt_count[p*16 +: 16], delivered[p]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.m_addr_axis_tready   = 1'b1;
        bus.m_packet_axis_tready = 1'b1;
        @(posedge clk); #1;
        bus.s_packet_axis_tvalid[2] = 1'b1;
        bus.s_packet_axis_tlast[2]  = 1'b0;
        bus.s_packet_axis_tdest[2*DTW +: DTW] = 32'hABCD_0002;
        bus.s_packet_axis_tdata[2*DW +: DW]   = {$urandom, $urandom};
        repeat (2) begin @(posedge clk); #1; end
        tests_run++;
        if ({bus.m_packet_axis_tvalid, grant} !== {1'b1, 2'd2}) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_flow: got pv %b grant %0d, required 1/2", bus.m_packet_axis_tvalid, grant);
        end
        repeat (2) begin @(posedge clk); #1; bus.s_packet_axis_tdata[2*DW +: DW] = {$urandom, $urandom}; end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({busy, bus.m_packet_axis_tvalid, bus.m_addr_axis_tvalid, bus.m_addr_axis_tlast,
             bus.s_packet_axis_tready} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_clear: got busy %b pv %b av %b al %b tready %b, required all 0",
                     busy, bus.m_packet_axis_tvalid, bus.m_addr_axis_tvalid, bus.m_addr_axis_tlast,
                     bus.s_packet_axis_tready);
        end
        bus.s_packet_axis_tvalid = 4'b1010;
        bus.s_packet_axis_tdest[1*DTW +: DTW] = 32'h0000_0011;
        bus.s_packet_axis_tdest[3*DTW +: DTW] = 32'h0000_0033;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, grant, bus.m_addr_axis_tdata} !== {1'b1, 2'd1, 32'h0000_0011}) begin
            tests_failed++;
            $display("[TB] FAIL restart_ptr: got busy %b grant %0d token %h, required 1/1/00000011",
                     busy, grant, bus.m_addr_axis_tdata);
        end
        bus.s_packet_axis_tvalid = '0;
    endtask

    initial begin
        bus.s_packet_axis_tvalid = '0;
        bus.s_packet_axis_tlast  = '0;
        bus.s_packet_axis_tdata  = '0;
        bus.s_packet_axis_tkeep  = '0;
        bus.s_packet_axis_tdest  = '0;
        bus.m_packet_axis_tready = 1'b0;
        bus.m_addr_axis_tready   = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_addr_backpressure();
        test_gaps();
        for (int r = 0; r < 4; r++) test_random_mix();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/axis_dest_scheduler.md
Name: axis_dest_scheduler

Overview:
- Round-robin, packet-granular scheduler that shares one packet-plus-address datapath among NUM_PORTS AXI-Stream packet sources.
- For each granted packet it first issues one destination token on the address stream, then forwards the packet beats with tdest attached.
- It feeds the packet/address dropper in front of the AXI-Stream switch.

Parameters:
- NUM_PORTS, 4, number of requesting packet sources (2..16)
- DATA_WIDTH, 64, packet tdata width; tkeep is DATA_WIDTH/8
- DEST_WIDTH, 32, destination/address width

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous active-low reset (asserted at 0)
- s_packet_axis_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data, port i at slice i
- s_packet_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  per-port keep
- s_packet_axis_tvalid  in  NUM_PORTS  per-port valid
- s_packet_axis_tlast  in  NUM_PORTS  per-port last
- s_packet_axis_tdest  in  NUM_PORTS*DEST_WIDTH  per-port destination, stable for the whole packet
- s_packet_axis_tready  out  NUM_PORTS  per-port ready
- m_packet_axis_tdata  out  DATA_WIDTH  forwarded data
- m_packet_axis_tkeep  out  DATA_WIDTH/8  forwarded keep
- m_packet_axis_tvalid  out  1  forwarded valid
- m_packet_axis_tlast  out  1  forwarded last
- m_packet_axis_tdest  out  DEST_WIDTH  latched destination
- m_packet_axis_tready  in  1  downstream ready
- m_addr_axis_tdata  out  DEST_WIDTH  destination token
- m_addr_axis_tvalid  out  1  token valid
- m_addr_axis_tlast  out  1  always 1 while tvalid
- m_addr_axis_tready  in  1  token ready
- grant  out  $clog2(NUM_PORTS)  index of the current owner
- busy  out  1  high in ADDR or DATA

Behaviour:
- States: IDLE, ADDR, DATA. Reset (rst=0, async) forces IDLE, pointer=0, grant=0, dest register=0.
- Reset values: all tvalid=0, all s tready=0, busy=0, m_addr_axis_tlast=0.
- IDLE: if any s tvalid is set, pick the first set bit searching from pointer upward with wrap. Register grant, capture that port's tdest into the dest register, go to ADDR, set pointer=(grant+1) mod NUM_PORTS. No requests: stay in IDLE, pointer unchanged. Nothing is consumed in IDLE.
- Grant-to-token latency: 1 cycle from the tvalid sample to m_addr_axis_tvalid.
- ADDR:
  - m_addr_axis_tvalid=1, tdata=dest register, tlast=1.
  - All s tready=0 and m_packet_axis_tvalid=0.
  - Handshake -> DATA. tready low: hold indefinitely, with tdata stable.
- DATA:
  - Combinational mux of the granted port to m_packet (tdata, tkeep, tvalid, tlast). m_packet_axis_tdest=dest register.
  - s_packet_axis_tready[grant]=m_packet_axis_tready; all other ports 0.
  - Source valid gaps and sink backpressure pass straight through. State is held until tlast completes a handshake, then -> IDLE.
- Minimum one IDLE cycle between packets; a single continuous requester therefore gets one packet every beats+2 cycles.
- Requests from other ports arriving in ADDR/DATA are ignored until IDLE; fairness is strict round-robin per packet.
- Single-beat packet (tlast on the first beat): ADDR -> DATA -> IDLE normally.
- Reset mid-packet: the packet is truncated and the remainder is the source's responsibility. No output glitch beyond async clear.
- No combinational path from m_addr_axis_tready to any m_packet output.

Optional Feature:
- Macro: AXIS_SCHED_PKT_CNT_EN.
- Defined: adds output pkt_count (NUM_PORTS*16) with one 16-bit counter per port. A counter increments on each tlast handshake of that port in DATA, saturates at 0xFFFF, and clears on reset.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package axis_sched_pkg holds:
  - the state typedef (IDLE/ADDR/DATA)
  - default width constants (DATA_WIDTH 64, DEST_WIDTH 32, KEEP_WIDTH)
  - counter width (16)
- Sub-module rr_arbiter: combinational round-robin picker. Inputs req[NUM_PORTS] and pointer; outputs gnt_idx and gnt_valid. The scheduler owns pointer update.

Test Plan:
- Port 0: 3-beat packet, tdest=0x00000005, sinks always ready -> one token 0x5 with tlast=1, then 3 beats in order with tlast on beat 3, grant=0. Total 5 cycles from first tvalid to the last beat.
- All 4 ports continuously valid after reset, 1-beat packets -> grant sequence 0,1,2,3,0,1 with tokens equal to each port's tdest.
- Port 2 valid, m_addr_axis_tready=0 for 10 cycles -> state ADDR, token held stable, s tready all 0, m_packet tvalid 0. Release -> packet flows.
- 8-beat packet with random source gaps and m_packet tready toggling 50% -> exactly 8 beats, order and tkeep preserved, no duplication.
- rst=0 asserted at beat 2 of 5 -> immediately all tvalid/tready 0, busy 0. After release, grant search restarts at port 0.
- With AXIS_SCHED_PKT_CNT_EN: 65537 single-beat packets on port 1 -> pkt_count[1]=0xFFFF, other counters 0.
